// File: rtl/rx_frame_packer.sv
// rx_frame_packer: packs Si4463 RX frames into 16-bit SRAM FIFO words.
// Words pass through a small tagged queue drained by a req/hint writer.
module rx_frame_packer #(
  parameter int SRAM_DEPTH = 131072,
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_start,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_valid,
  input  logic        rx_abort,
  output logic        SRAM_write,
  output logic [15:0] Data_to_sram,
  input  logic        SRAM_hint,
  input  logic        SRAM_full,
  input  logic [17:0] SRAM_count,
  output logic        Pkt_Received_int,
  output logic [7:0]  drop_count,
  output logic        overrun,
  output logic        busy
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);
  localparam logic [19:0] DEPTH = 20'(SRAM_DEPTH);
  localparam logic [15:0] SYNC = 16'h2DD4;

  typedef enum logic [1:0] {IDLE, LEN, DATA, DISCARD} fstate_t;
  typedef enum logic {W_IDLE, W_REQ} wstate_t;
  typedef struct packed {
    logic        last;
    logic [15:0] word;
  } entry_t;

  fstate_t fstate, fstate_nx;
  wstate_t wstate, wstate_nx;

  entry_t        queue [QDEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  logic [7:0] remain, remain_nx;
  logic [7:0] hi, hi_nx;
  logic       half, half_nx;

  entry_t      enq_entry;
  logic        enq_req, enq, spill, full;
  logic        pop, load, drop;
  logic [19:0] need;

  assign full  = (count == QFULL);
  assign enq   = enq_req && !full;
  assign spill = enq_req && full;

  // words this frame needs: sync, {L,b0}, then one per remaining byte pair
  assign need = 20'(SRAM_count) + 20'(count) + 20'd2 + 20'(rx_byte[7:1]);

  always_comb begin
    fstate_nx = fstate;
    remain_nx = remain;
    hi_nx     = hi;
    half_nx   = half;
    enq_req   = 1'b0;
    enq_entry = '0;
    drop      = 1'b0;
    if (rx_start || rx_abort) begin
      drop      = (fstate != IDLE);
      fstate_nx = rx_start ? LEN : IDLE;
    end else begin
      unique case (fstate)
        IDLE: fstate_nx = IDLE;
        LEN: begin
          if (rx_byte_valid) begin
            remain_nx = rx_byte;
            if (rx_byte == 8'd0 || need > DEPTH) begin
              drop      = 1'b1;
              fstate_nx = DISCARD;
            end else begin
              enq_req   = 1'b1;
              enq_entry = {1'b0, SYNC};
              hi_nx     = rx_byte;
              half_nx   = 1'b1;
              fstate_nx = DATA;
            end
          end
        end
        DATA: begin
          if (rx_byte_valid) begin
            remain_nx = remain - 8'd1;
            if (half) begin
              enq_req   = 1'b1;
              enq_entry = {remain == 8'd1, hi, rx_byte};
              half_nx   = 1'b0;
            end else begin
              hi_nx   = rx_byte;
              half_nx = 1'b1;
              if (remain == 8'd1) begin
                enq_req   = 1'b1;
                enq_entry = {1'b1, rx_byte, 8'h00};
              end
            end
            if (remain == 8'd1) fstate_nx = IDLE;
          end
        end
        DISCARD: begin
          if (remain == 8'd0) begin
            fstate_nx = IDLE;
          end else if (rx_byte_valid) begin
            remain_nx = remain - 8'd1;
            if (remain == 8'd1) fstate_nx = IDLE;
          end
        end
      endcase
      // a word that cannot be queued kills the rest of the frame
      if (spill) begin
        drop      = 1'b1;
        fstate_nx = DISCARD;
      end
    end
  end

  always_comb begin
    wstate_nx = wstate;
    load      = 1'b0;
    pop       = 1'b0;
    unique case (wstate)
      W_IDLE: begin
        if (count != '0 && !SRAM_full) begin
          load      = 1'b1;
          wstate_nx = W_REQ;
        end
      end
      W_REQ: begin
        if (SRAM_hint) begin
          pop       = 1'b1;
          wstate_nx = W_IDLE;
        end
      end
    endcase
  end

  assign SRAM_write       = (wstate == W_REQ);
  assign Pkt_Received_int = pop && !reset && queue[rptr].last;
  assign busy             = (fstate != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (enq) queue[wptr] <= enq_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fstate       <= IDLE;
      wstate       <= W_IDLE;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      remain       <= '0;
      hi           <= '0;
      half         <= 1'b0;
      Data_to_sram <= '0;
      drop_count   <= '0;
      overrun      <= 1'b0;
    end else begin
      fstate <= fstate_nx;
      wstate <= wstate_nx;
      remain <= remain_nx;
      hi     <= hi_nx;
      half   <= half_nx;
      if (enq) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(enq) - CW'(pop);
      if (load) Data_to_sram <= queue[rptr].word;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (spill) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_frame_packer.sv
// tb_rx_frame_packer: directed and random frames vs a frame-level model.
// DUT outputs are compared to the model on every falling edge.
module tb_rx_frame_packer;
  localparam int DEPTH = 131072;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_start = 1'b0;
  logic        rx_byte_valid = 1'b0;
  logic        rx_abort = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        SRAM_write;
  logic [15:0] Data_to_sram;
  logic        SRAM_hint = 1'b0;
  logic        SRAM_full = 1'b0;
  logic [17:0] SRAM_count = 18'd0;
  logic        Pkt_Received_int;
  logic [7:0]  drop_count;
  logic        overrun;
  logic        busy;

  int checks = 0;
  int errors = 0;

  rx_frame_packer #(.SRAM_DEPTH(DEPTH), .QDEPTH(QD)) dut (
    .clk(clk),
    .reset(reset),
    .rx_start(rx_start),
    .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .rx_abort(rx_abort),
    .SRAM_write(SRAM_write),
    .Data_to_sram(Data_to_sram),
    .SRAM_hint(SRAM_hint),
    .SRAM_full(SRAM_full),
    .SRAM_count(SRAM_count),
    .Pkt_Received_int(Pkt_Received_int),
    .drop_count(drop_count),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // model: frame mode 0 idle, 1 length, 2 payload, 3 skipping
  int          m_mode = 0;
  int          m_len = 0;
  int          m_idx = 0;
  int          m_skip = 0;
  logic [7:0]  m_hold = 8'h00;
  logic [16:0] m_q [$];
  bit          m_wreq = 1'b0;
  logic [15:0] m_wdata = 16'h0;
  int          m_drops = 0;
  bit          m_ovr = 1'b0;

  always @(posedge clk) begin
    int sz0;
    int need;
    bit enq;
    bit drop_ev;
    logic [16:0] e;
    if (reset) begin
      m_mode = 0;
      m_q.delete();
      m_wreq = 1'b0;
      m_wdata = 16'h0;
      m_drops = 0;
      m_ovr = 1'b0;
    end else begin
      sz0 = m_q.size();
      enq = 1'b0;
      drop_ev = 1'b0;
      e = '0;
      if (rx_start || rx_abort) begin
        if (m_mode != 0) drop_ev = 1'b1;
        m_mode = rx_start ? 1 : 0;
      end else if (m_mode == 1) begin
        if (rx_byte_valid) begin
          m_len = rx_byte;
          m_idx = 0;
          need = int'(SRAM_count) + sz0 + 2 + m_len / 2;
          if (m_len == 0 || need > DEPTH) begin
            drop_ev = 1'b1;
            m_mode = 3;
            m_skip = m_len;
          end else begin
            enq = 1'b1;
            e = {1'b0, 16'h2DD4};
            m_mode = 2;
          end
        end
      end else if (m_mode == 2) begin
        if (rx_byte_valid) begin
          if (m_idx == 0) begin
            enq = 1'b1;
            e = {m_len == 1, 8'(m_len), rx_byte};
          end else if (m_idx % 2 == 1) begin
            m_hold = rx_byte;
            if (m_idx == m_len - 1) begin
              enq = 1'b1;
              e = {1'b1, rx_byte, 8'h00};
            end
          end else begin
            enq = 1'b1;
            e = {m_idx == m_len - 1, m_hold, rx_byte};
          end
          m_idx++;
          if (m_idx == m_len) m_mode = 0;
        end
      end else if (m_mode == 3) begin
        if (m_skip == 0) m_mode = 0;
        else if (rx_byte_valid) begin
          m_skip--;
          if (m_skip == 0) m_mode = 0;
        end
      end
      if (enq && sz0 == QD) begin
        enq = 1'b0;
        m_ovr = 1'b1;
        drop_ev = 1'b1;
        m_mode = 3;
        m_skip = m_len - m_idx;
      end
      if (m_wreq) begin
        if (SRAM_hint) begin
          void'(m_q.pop_front());
          m_wreq = 1'b0;
        end
      end else if (sz0 != 0 && !SRAM_full) begin
        m_wreq = 1'b1;
        m_wdata = m_q[0][15:0];
      end
      if (enq) m_q.push_back(e);
      if (drop_ev && m_drops < 255) m_drops++;
    end
  end

  logic [15:0] dlog [$];
  int npulse = 0;
  int pulse_at = -1;

  always @(negedge clk) begin
    bit ep;
    bit eb;
    ep = !reset && m_wreq && SRAM_hint && m_q.size() > 0 && m_q[0][16];
    eb = (m_mode != 0) || (m_q.size() != 0);
    checks++;
    if (SRAM_write !== m_wreq || Data_to_sram !== m_wdata ||
        Pkt_Received_int !== ep || drop_count !== 8'(m_drops) ||
        overrun !== m_ovr || busy !== eb) begin
      errors++;
      $display("FAIL cycle t=%0t got/exp wr=%b/%b data=%h/%h pulse=%b/%b drops=%0d/%0d ovr=%b/%b busy=%b/%b",
               $time, SRAM_write, m_wreq, Data_to_sram, m_wdata,
               Pkt_Received_int, ep, drop_count, m_drops,
               overrun, m_ovr, busy, eb);
    end
    if (SRAM_write && SRAM_hint) dlog.push_back(Data_to_sram);
    if (Pkt_Received_int) begin
      npulse++;
      pulse_at = dlog.size();
    end
  end

  bit hold = 1'b0;
  bit rand_lat = 1'b0;
  bit rand_full = 1'b0;
  int lat = 1;
  int cnt = 0;

  always @(posedge clk) begin
    #1;
    SRAM_full = rand_full ? ($urandom_range(0, 7) == 0) : 1'b0;
    if (SRAM_hint) SRAM_hint = 1'b0;
    else if (SRAM_write && !hold) begin
      if (cnt >= lat) begin
        SRAM_hint = 1'b1;
        cnt = 0;
        lat = rand_lat ? int'($urandom_range(0, 3)) : 1;
      end else cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic start();
    rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
    gap();
  endtask

  task automatic put(input logic [7:0] b);
    rx_byte = b;
    rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0;
    gap();
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || SRAM_write) && n < 3000) begin
      tick();
      n++;
    end
    chk({name, "_idle_timeout"}, n >= 3000, 0);
  endtask

  task automatic clr();
    dlog.delete();
    npulse = 0;
    pulse_at = -1;
  endtask

  task automatic chk_log(input string name, input logic [15:0] exp [$],
                         input int pulses);
    chk({name, "_nwords"}, dlog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < dlog.size(); i++)
      chk($sformatf("%s_w%0d", name, i), dlog[i], exp[i]);
    chk({name, "_pulses"}, npulse, pulses);
  endtask

  initial begin
    logic [15:0] exp [$];
    int n;
    int len;

    reset = 1'b1;
    repeat (3) tick();
    chk("rst_write", SRAM_write, 0);
    chk("rst_data", Data_to_sram, 0);
    chk("rst_pulse", Pkt_Received_int, 0);
    chk("rst_drops", drop_count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    clr();
    start();
    put(8'd3); put(8'hAA); put(8'hBB); put(8'hCC);
    wait_idle("t1");
    exp = {16'h2DD4, 16'h03AA, 16'hBBCC};
    chk_log("t1", exp, 1);
    chk("t1_pulse_at_3rd", pulse_at, 3);

    clr();
    start();
    put(8'd2); put(8'h11); put(8'h22);
    wait_idle("t2");
    exp = {16'h2DD4, 16'h0211, 16'h2200};
    chk_log("t2", exp, 1);

    clr();
    start();
    put(8'd0);
    repeat (3) tick();
    SRAM_count = 18'(DEPTH - 2);
    start();
    put(8'd5);
    for (int i = 0; i < 5; i++) put(8'(i + 1));
    SRAM_count = 18'd0;
    wait_idle("t3a");
    chk("t3_nwords", dlog.size(), 0);
    chk("t3_drops", drop_count, 2);
    chk("t3_model_drops", m_drops, 2);
    clr();
    start();
    put(8'd4); put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    wait_idle("t3b");
    exp = {16'h2DD4, 16'h0401, 16'h0203, 16'h0400};
    chk_log("t3b", exp, 1);

    clr();
    start();
    put(8'd6); put(8'h5A); put(8'h11); put(8'h22);
    rx_abort = 1'b1;
    tick();
    rx_abort = 1'b0;
    wait_idle("t4a");
    exp = {16'h2DD4, 16'h065A, 16'h1122};
    chk_log("t4a", exp, 0);
    chk("t4_drops", drop_count, 3);
    clr();
    start();
    put(8'd1); put(8'h77);
    wait_idle("t4b");
    exp = {16'h2DD4, 16'h0177};
    chk_log("t4b", exp, 1);

    clr();
    hold = 1'b1;
    start();
    put(8'd9);
    for (int i = 0; i < 9; i++) put(8'(8'h10 + i));
    repeat (100) tick();
    chk("t5_overrun", overrun, 1);
    chk("t5_drops", drop_count, 4);
    chk("t5_held_words", dlog.size(), 0);
    chk("t5_busy_held", busy, 1);
    hold = 1'b0;
    wait_idle("t5");
    exp = {16'h2DD4, 16'h0910, 16'h1112, 16'h1314};
    chk_log("t5", exp, 0);
    chk("t5_busy_after", busy, 0);

    rand_lat = 1'b1;
    rand_full = 1'b1;
    for (int f = 0; f < 60; f++) begin
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
      SRAM_count = ($urandom_range(0, 5) == 0) ?
                   18'(DEPTH - int'($urandom_range(0, 16))) :
                   18'($urandom_range(0, 1000));
      start();
      put(8'(len));
      for (int i = 0; i < len; i++) begin
        n = $urandom_range(0, 99);
        if (n == 0) begin
          rx_abort = 1'b1;
          rx_byte_valid = 1'b1;
          tick();
          rx_abort = 1'b0;
          rx_byte_valid = 1'b0;
          break;
        end else if (n == 1) begin
          rx_start = 1'b1;
          rx_byte_valid = 1'b1;
          tick();
          rx_start = 1'b0;
          rx_byte_valid = 1'b0;
        end else put(8'($urandom));
      end
      if ($urandom_range(0, 3) == 0) wait_idle("rnd");
      else repeat ($urandom_range(0, 4)) tick();
    end
    rand_full = 1'b0;
    rand_lat = 1'b0;
    rx_abort = 1'b1;
    tick();
    rx_abort = 1'b0;
    SRAM_count = 18'd0;
    wait_idle("rnd_end");

    repeat (260) begin
      start();
      put(8'd0);
      tick();
      tick();
    end
    chk("sat_drops", drop_count, 255);

    hold = 1'b1;
    start();
    put(8'd2); put(8'h01); put(8'h02);
    n = 0;
    while (!SRAM_write && n < 20) begin
      tick();
      n++;
    end
    chk("t6_write_before", SRAM_write, 1);
    reset = 1'b1;
    tick();
    chk("t6_write", SRAM_write, 0);
    chk("t6_data", Data_to_sram, 0);
    chk("t6_pulse", Pkt_Received_int, 0);
    chk("t6_drops", drop_count, 0);
    chk("t6_overrun", overrun, 0);
    chk("t6_busy", busy, 0);
    reset = 1'b0;
    hold = 1'b0;
    tick();
    clr();
    start();
    put(8'd1); put(8'h33);
    wait_idle("t6");
    exp = {16'h2DD4, 16'h0133};
    chk_log("t6", exp, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
